// File: rtl/sha256_nonce_sched.sv
// Nonce search scheduler driving a shared SHA-256 core, one nonce per attempt.
// Define SCHED_DOUBLE_HASH_EN for double SHA-256 (PASS1 -> GAP -> PASS2).
module sha256_nonce_sched #(
  parameter int CORE_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         abort,
  input  logic [607:0] header,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [255:0] target,
  output logic         core_start,
  output logic [639:0] core_block,
  input  logic [255:0] core_hash,
  input  logic         core_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [31:0]  attempts
);

  typedef enum logic [2:0] {IDLE, PASS1, GAP, PASS2, CHECK, DONE} state_t;

  localparam int CW = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CORE_TIMEOUT - 1);

  state_t        state, state_nx;
  logic [31:0]   cur_nonce;
  logic [255:0]  hash1;
  logic [255:0]  cmp_hash;
  logic [CW-1:0] cnt;
  logic          in_pass;
  logic          timeout_hit;
  logic          start_search;

`ifdef SCHED_DOUBLE_HASH_EN
  logic [255:0]  hash2;
  assign cmp_hash = hash2;
`else
  assign cmp_hash = hash1;
`endif

  assign in_pass      = (state == PASS1) || (state == PASS2);
  assign timeout_hit  = (cnt == CNT_MAX);
  assign start_search = ((state == IDLE) || (state == DONE)) && (state_nx == PASS1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Abort outranks everything, including a core_done arriving in the same cycle.
  always_comb begin
    state_nx = state;
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (go) state_nx = PASS1;
        PASS1: begin
          if (core_done) begin
`ifdef SCHED_DOUBLE_HASH_EN
            state_nx = GAP;
`else
            state_nx = CHECK;
`endif
          end else if (timeout_hit) begin
            state_nx = DONE;
          end
        end
        GAP:   state_nx = PASS2;
        PASS2: begin
          if (core_done)        state_nx = CHECK;
          else if (timeout_hit) state_nx = DONE;
        end
        CHECK: begin
          if (cmp_hash <= target)           state_nx = DONE;
          else if (cur_nonce == nonce_last) state_nx = DONE;
          else                              state_nx = PASS1;
        end
        DONE:  if (go) state_nx = PASS1;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    core_start = in_pass;
    busy       = (state != IDLE) && (state != DONE);
    core_block = '0;
    case (state)
      PASS1:   core_block = {header, cur_nonce};
      PASS2:   core_block = {hash1, 1'b1, 383'b0};
      default: core_block = '0;
    endcase
  end

  // The pass timer restarts on every state change, so each pass gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_nonce    <= '0;
      hash1        <= '0;
`ifdef SCHED_DOUBLE_HASH_EN
      hash2        <= '0;
`endif
      cnt          <= '0;
      found        <= 1'b0;
      exhausted    <= 1'b0;
      timeout_err  <= 1'b0;
      result_nonce <= '0;
      result_hash  <= '0;
      attempts     <= '0;
    end else begin
      if (state_nx != state) cnt <= '0;
      else                   cnt <= cnt + CW'(1);

      if (start_search) begin
        cur_nonce   <= nonce_first;
        found       <= 1'b0;
        exhausted   <= 1'b0;
        timeout_err <= 1'b0;
        attempts    <= '0;
      end

      if (in_pass && (state_nx == DONE)) timeout_err <= 1'b1;

      if ((state == PASS1) && core_done && !abort) begin
        hash1 <= core_hash;
`ifndef SCHED_DOUBLE_HASH_EN
        attempts <= attempts + 32'd1;
`endif
      end

`ifdef SCHED_DOUBLE_HASH_EN
      if ((state == PASS2) && core_done && !abort) begin
        hash2    <= core_hash;
        attempts <= attempts + 32'd1;
      end
`endif

      if ((state == CHECK) && !abort) begin
        if (cmp_hash <= target) begin
          found        <= 1'b1;
          result_nonce <= cur_nonce;
          result_hash  <= cmp_hash;
        end else if (cur_nonce == nonce_last) begin
          exhausted <= 1'b1;
        end else begin
          cur_nonce <= cur_nonce + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Scoreboard bench for sha256_nonce_sched with a fixed-latency behavioural core.
module tb_sha256_nonce_sched;

  localparam int TMO = 20;
`ifdef SCHED_DOUBLE_HASH_EN
  localparam int PASSES_PER_TRY = 2;
`else
  localparam int PASSES_PER_TRY = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic         abort = 1'b0;
  logic [607:0] header;
  logic [31:0]  nonce_first = '0;
  logic [31:0]  nonce_last = '0;
  logic [255:0] target = '0;
  logic         core_start;
  logic [639:0] core_block;
  logic [255:0] core_hash;
  logic         core_done;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  result_nonce, attempts;
  logic [255:0] result_hash;

  typedef struct {
    string        name;
    logic         found;
    logic         exhausted;
    logic         tmo;
    logic         chk_result;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic [31:0]  attempts;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] nonce_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          failed = 0;
  logic        core_enable = 1'b1;
  logic [31:0] match_nonce = 32'hFFFF_FF00;
  logic [2:0]  lat_cnt;

  sha256_nonce_sched #(.CORE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .header(header),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
    .core_start(core_start), .core_block(core_block), .core_hash(core_hash),
    .core_done(core_done), .busy(busy), .found(found), .exhausted(exhausted),
    .timeout_err(timeout_err), .result_nonce(result_nonce),
    .result_hash(result_hash), .attempts(attempts)
  );

  always #5 clk = ~clk;

  // Second-pass blocks are recognised by the pad bit and echo hash1, so both builds yield the same final hash.
  function automatic logic [255:0] model_hash(input logic [639:0] blk);
    if (blk[383] && (blk[382:0] == 383'd0)) return blk[639:384];
    else if (blk[31:0] == match_nonce)      return 256'h5;
    else                                    return {blk[31:0] | 32'h8000_0000, 224'd0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_hash <= '0;
      lat_cnt   <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start && !core_done && core_enable) begin
        if (lat_cnt == 3'd3) begin
          core_done <= 1'b1;
          core_hash <= model_hash(core_block);
          lat_cnt   <= '0;
        end else begin
          lat_cnt <= lat_cnt + 3'd1;
        end
      end else begin
        lat_cnt <= '0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy ends a search; a rising core_start on a first pass shows the nonce.
  initial begin : monitor
    logic busy_q, cs_q;
    busy_q = 1'b0;
    cs_q   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && busy_q && !busy && (sb_q.size() > 0)) begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.name, ".core_start"}, 640'(core_start), 640'(0));
        checkOutput({mon_e.name, ".found"}, 640'(found), 640'(mon_e.found));
        checkOutput({mon_e.name, ".exhausted"}, 640'(exhausted), 640'(mon_e.exhausted));
        checkOutput({mon_e.name, ".timeout_err"}, 640'(timeout_err), 640'(mon_e.tmo));
        checkOutput({mon_e.name, ".attempts"}, 640'(attempts), 640'(mon_e.attempts));
        if (mon_e.chk_result) begin
          checkOutput({mon_e.name, ".result_nonce"}, 640'(result_nonce), 640'(mon_e.nonce));
          checkOutput({mon_e.name, ".result_hash"}, 640'(result_hash), 640'(mon_e.hash));
        end
      end
      if (rst_n && !cs_q && core_start && (nonce_q.size() > 0) &&
          !(core_block[383] && (core_block[382:0] == 383'd0)))
        checkOutput("nonce_seq", 640'(core_block[31:0]), 640'(nonce_q.pop_front()));
      busy_q = busy;
      cs_q   = core_start;
    end
  end

  task automatic pulseGo();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic waitScoreboard(input string name, input int bound);
    int n;
    n = 0;
    while ((sb_q.size() > 0) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s: no completion within %0d cycles, expected done", name, bound);
      sb_q.delete();
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt, input exp_t e, input int extra_go_at);
    nonce_first = first;
    nonce_last  = last;
    target      = tgt;
    sb_q.push_back(e);
    pulseGo();
    if (extra_go_at > 0) begin
      repeat (extra_go_at) @(negedge clk);
      go = 1'b1;
      @(negedge clk) go = 1'b0;
    end
    waitScoreboard(name, 500);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".core_start"}, 640'(core_start), 640'(0));
    checkOutput({tag, ".core_block"}, core_block, 640'(0));
    checkOutput({tag, ".busy"}, 640'(busy), 640'(0));
    checkOutput({tag, ".found"}, 640'(found), 640'(0));
    checkOutput({tag, ".exhausted"}, 640'(exhausted), 640'(0));
    checkOutput({tag, ".timeout_err"}, 640'(timeout_err), 640'(0));
    checkOutput({tag, ".result_nonce"}, 640'(result_nonce), 640'(0));
    checkOutput({tag, ".result_hash"}, 640'(result_hash), 640'(0));
    checkOutput({tag, ".attempts"}, 640'(attempts), 640'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    int   rises, n, cyc;
    logic csq;

    header = {19{32'h1234_5678}};
    repeat (3) @(negedge clk);
    checkAllZero("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("reset_idle");

    // Single-nonce range with an all-ones target always matches.
    e = '{name: "single", found: 1'b1, exhausted: 1'b0, tmo: 1'b0, chk_result: 1'b1,
          nonce: 32'h10, hash: {32'h8000_0010, 224'd0}, attempts: 32'd1};
    applyStimulus("single", 32'h10, 32'h10, {256{1'b1}}, e, 0);

    // Wrapping range with an unreachable target.
    nonce_q.push_back(32'hFFFF_FFFE);
    nonce_q.push_back(32'hFFFF_FFFF);
    nonce_q.push_back(32'h0000_0000);
    nonce_q.push_back(32'h0000_0001);
    e = '{name: "wrap", found: 1'b0, exhausted: 1'b1, tmo: 1'b0, chk_result: 1'b0,
          nonce: 32'h0, hash: 256'h0, attempts: 32'd4};
    applyStimulus("wrap", 32'hFFFF_FFFE, 32'h0000_0001, 256'h0, e, 0);
    checkOutput("wrap.nonces_left", 640'(nonce_q.size()), 640'(0));

    // Only nonce 5 matches; a stray go mid-search must be ignored.
    match_nonce = 32'h5;
    e = '{name: "match5", found: 1'b1, exhausted: 1'b0, tmo: 1'b0, chk_result: 1'b1,
          nonce: 32'h5, hash: 256'h5, attempts: 32'd6};
    applyStimulus("match5", 32'h0, 32'h9, 256'h10, e, 8);
    repeat (5) @(negedge clk);
    checkOutput("done_hold.found", 640'(found), 640'(1));
    checkOutput("done_hold.result_nonce", 640'(result_nonce), 640'(32'h5));
    checkOutput("done_hold.busy", 640'(busy), 640'(0));

    // Abort during the hashing pass that completes the third attempt.
    match_nonce = 32'hFFFF_FF00;
    nonce_first = 32'h0;
    nonce_last  = 32'h9;
    target      = 256'h0;
    pulseGo();
    rises = 0;
    csq   = 1'b0;
    n     = 0;
    while ((rises < 3 * PASSES_PER_TRY) && (n < 500)) begin
      if (!csq && core_start) rises++;
      csq = core_start;
      if (rises < 3 * PASSES_PER_TRY) begin
        @(negedge clk);
        n++;
      end
    end
    if (rises < 3 * PASSES_PER_TRY) begin
      tests++;
      failed++;
      $display("[TB] FAIL abort.reach: saw %0d core starts, expected %0d", rises, 3 * PASSES_PER_TRY);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.core_start", 640'(core_start), 640'(0));
    checkOutput("abort.busy", 640'(busy), 640'(0));
    checkOutput("abort.found", 640'(found), 640'(0));
    checkOutput("abort.exhausted", 640'(exhausted), 640'(0));
    checkOutput("abort.attempts", 640'(attempts), 640'(2));

    // Silent core: the pass must time out after exactly TMO cycles of core_start.
    core_enable = 1'b0;
    e = '{name: "timeout", found: 1'b0, exhausted: 1'b0, tmo: 1'b1, chk_result: 1'b0,
          nonce: 32'h0, hash: 256'h0, attempts: 32'd0};
    sb_q.push_back(e);
    pulseGo();
    cyc = 0;
    n   = 0;
    while (busy && (n < 200)) begin
      if (core_start) cyc++;
      @(negedge clk);
      n++;
    end
    checkOutput("timeout.start_cycles", 640'(cyc), 640'(TMO));
    waitScoreboard("timeout", 10);
    core_enable = 1'b1;

    // Reset mid-search clears everything, including the previous result.
    nonce_first = 32'h0;
    nonce_last  = 32'h9;
    target      = 256'h0;
    pulseGo();
    repeat (15) @(negedge clk);
    checkOutput("pre_reset.busy", 640'(busy), 640'(1));
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    e = '{name: "post_reset", found: 1'b1, exhausted: 1'b0, tmo: 1'b0, chk_result: 1'b1,
          nonce: 32'h10, hash: {32'h8000_0010, 224'd0}, attempts: 32'd1};
    applyStimulus("post_reset", 32'h10, 32'h10, {256{1'b1}}, e, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
